// File: rtl/sim_result_mailbox_pkg.sv
// Shared constants, types and helpers for the simulation result mailbox.
package sim_result_mailbox_pkg;

    localparam int unsigned CH_STRIDE = 32;
    localparam int unsigned CH_IDX_W  = 4;
    localparam int unsigned MAX_CH    = 16;
    localparam int unsigned WORD_W    = 32;

    localparam logic [4:0] OFF_CHECK  = 5'h00;
    localparam logic [4:0] OFF_FINISH = 5'h04;
    localparam logic [4:0] OFF_TYPE   = 5'h08;
    localparam logic [4:0] OFF_INDEX  = 5'h0C;
    localparam logic [4:0] OFF_RESULT = 5'h10;
    localparam logic [4:0] OFF_EXPECT = 5'h14;
    localparam logic [4:0] OFF_RSV0   = 5'h18;
    localparam logic [4:0] OFF_RSV1   = 5'h1C;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_e;

    // Failure report frozen at the verdict.
    typedef struct packed {
        logic [CH_IDX_W-1:0] ch;
        logic [WORD_W-1:0]   ftype;
        logic [WORD_W-1:0]   index;
        logic [WORD_W-1:0]   result;
        logic [WORD_W-1:0]   expected;
    } fail_report_t;

    function automatic logic [WORD_W-1:0] byte_swap(input logic [WORD_W-1:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/sim_result_mailbox_channel.sv
// One mailbox channel: report registers plus check/finished flags.
// Ports: clk_i/rst_ni clock and async reset, clear_i sync restart,
// we_i/off_i/wdata_i accepted write, finished_o registered finish bit,
// fin_nxt_c_o/fin_flag_nxt_c_o finish state as it will be after this edge,
// type_o/index_o/result_o/expect_o stored report words.
module sim_result_mailbox_channel
    import sim_result_mailbox_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              we_i,
    input  logic [4:0]        off_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic              finished_o,
    output logic              fin_nxt_c_o,
    output logic              fin_flag_nxt_c_o,
    output logic [WORD_W-1:0] type_o,
    output logic [WORD_W-1:0] index_o,
    output logic [WORD_W-1:0] result_o,
    output logic [WORD_W-1:0] expect_o
);

    logic              flag_q;
    logic              fin_q;
    logic              fin_flag_q;
    logic [WORD_W-1:0] type_q;
    logic [WORD_W-1:0] index_q;
    logic [WORD_W-1:0] result_q;
    logic [WORD_W-1:0] expect_q;
    logic              fin_we;

    assign fin_we = we_i && (off_i == OFF_FINISH);

    // Register bank; the flag is latched into fin_flag_q when FINISH lands.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            flag_q     <= 1'b0;
            fin_q      <= 1'b0;
            fin_flag_q <= 1'b0;
            type_q     <= '0;
            index_q    <= '0;
            result_q   <= '0;
            expect_q   <= '0;
        end else if (clear_i) begin
            flag_q     <= 1'b0;
            fin_q      <= 1'b0;
            fin_flag_q <= 1'b0;
            type_q     <= '0;
            index_q    <= '0;
            result_q   <= '0;
            expect_q   <= '0;
        end else if (we_i) begin
            case (off_i)
                OFF_CHECK:  flag_q   <= wdata_i[0];
                OFF_FINISH: begin
                    fin_q      <= 1'b1;
                    fin_flag_q <= flag_q;
                end
                OFF_TYPE:   type_q   <= wdata_i;
                OFF_INDEX:  index_q  <= wdata_i;
                OFF_RESULT: result_q <= wdata_i;
                OFF_EXPECT: expect_q <= wdata_i;
                default: ;
            endcase
        end
    end

    assign fin_nxt_c_o      = fin_q | fin_we;
    assign fin_flag_nxt_c_o = fin_we ? flag_q : fin_flag_q;
    assign finished_o       = fin_q;
    assign type_o           = type_q;
    assign index_o          = index_q;
    assign result_o         = result_q;
    assign expect_o         = expect_q;

endmodule

// File: rtl/sim_result_mailbox.sv
// Bus-snooping result mailbox: decodes word writes into P_CH channels,
// runs the verdict FSM and watchdog, and reports the lowest failing channel.
// Ports: iCLOCK/inRESET clock and async reset, iCLEAR sync restart,
// iMEMORY_* snooped request, oDONE/oPASS/oFAIL/oTIMEOUT verdict,
// oFINISHED_MASK finished channels, oFAIL_* failing channel report,
// oBAD_ACCESS sticky misuse flag, oACCEPT_COUNT accepted writes.
module sim_result_mailbox
    import sim_result_mailbox_pkg::*;
#(
    parameter logic [31:0] P_BASE_ADDR     = 32'h0002_0000,
    parameter int unsigned P_CH            = 1,
    parameter bit          P_BYTE_SWAP     = 1'b1,
    parameter bit          P_ABORT_ON_FAIL = 1'b0,
    parameter logic [31:0] P_TIMEOUT       = 32'd750000
) (
    input  logic            iCLOCK,
    input  logic            inRESET,
    input  logic            iCLEAR,
    input  logic            iMEMORY_REQ,
    input  logic            iMEMORY_LOCK,
    input  logic            iMEMORY_RW,
    input  logic [1:0]      iMEMORY_ORDER,
    input  logic [31:0]     iMEMORY_ADDR,
    input  logic [31:0]     iMEMORY_DATA,
    output logic            oDONE,
    output logic            oPASS,
    output logic            oFAIL,
    output logic            oTIMEOUT,
    output logic [P_CH-1:0] oFINISHED_MASK,
    output logic [3:0]      oFAIL_CH,
    output logic [31:0]     oFAIL_TYPE,
    output logic [31:0]     oFAIL_INDEX,
    output logic [31:0]     oFAIL_RESULT,
    output logic [31:0]     oFAIL_EXPECT,
    output logic            oBAD_ACCESS,
    output logic [15:0]     oACCEPT_COUNT
);

    localparam logic [31:0] WIN_BYTES = 32'(P_CH * CH_STRIDE);

    state_e              state_q, state_d;
    logic                done_q, pass_q, fail_q, tout_q;
    logic                done_d, pass_d, fail_d, tout_d;
    fail_report_t        report_q, report_d, rep_sel;
    logic [31:0]         wd_q;
    logic [15:0]         cnt_q;
    logic                bad_q;

    logic [31:0]         win_off;
    logic                in_win, fmt_ok, reserved, fin_dup, run, hit, acc, bad, fin_acc, wd_expire;
    logic [CH_IDX_W-1:0] ch_sel;
    logic [4:0]          off;
    logic [WORD_W-1:0]   wdata;

    logic [P_CH-1:0]     ch_we, fin_q, fin_nxt, fflag_nxt;
    logic [MAX_CH-1:0]   fin_pad, fflag_pad;
    logic [WORD_W-1:0]   type_a   [P_CH];
    logic [WORD_W-1:0]   index_a  [P_CH];
    logic [WORD_W-1:0]   result_a [P_CH];
    logic [WORD_W-1:0]   expect_a [P_CH];

    // Address decode and access classification.
    assign win_off   = iMEMORY_ADDR - P_BASE_ADDR;
    assign in_win    = (iMEMORY_ADDR >= P_BASE_ADDR) && (win_off < WIN_BYTES);
    assign ch_sel    = win_off[8:5];
    assign off       = iMEMORY_ADDR[4:0];
    assign wdata     = P_BYTE_SWAP ? byte_swap(iMEMORY_DATA) : iMEMORY_DATA;
    assign fin_pad   = MAX_CH'(fin_q);
    assign fflag_pad = MAX_CH'(fflag_nxt);
    assign fmt_ok    = (iMEMORY_ORDER == 2'h2) && (iMEMORY_ADDR[1:0] == 2'b00);
    assign reserved  = (off == OFF_RSV0) || (off == OFF_RSV1);
    assign fin_dup   = (off == OFF_FINISH) && fin_pad[ch_sel];
    assign run       = (state_q == ST_RUN);
    assign hit       = run && iMEMORY_REQ && !iMEMORY_LOCK && iMEMORY_RW && in_win;
    assign bad       = hit && (!fmt_ok || reserved || fin_dup);
    assign acc       = hit && fmt_ok && !reserved && !fin_dup && !iCLEAR;
    assign fin_acc   = acc && (off == OFF_FINISH);
    assign wd_expire = (P_TIMEOUT != 32'd0) && (wd_q == P_TIMEOUT - 32'd1);

    for (genvar g = 0; g < int'(P_CH); g++) begin : g_ch
        assign ch_we[g] = acc && (ch_sel == CH_IDX_W'(g));
        sim_result_mailbox_channel u_ch (
            .clk_i            (iCLOCK),
            .rst_ni           (inRESET),
            .clear_i          (iCLEAR),
            .we_i             (ch_we[g]),
            .off_i            (off),
            .wdata_i          (wdata),
            .finished_o       (fin_q[g]),
            .fin_nxt_c_o      (fin_nxt[g]),
            .fin_flag_nxt_c_o (fflag_nxt[g]),
            .type_o           (type_a[g]),
            .index_o          (index_a[g]),
            .result_o         (result_a[g]),
            .expect_o         (expect_a[g])
        );
    end

    // Lowest-numbered channel that has finished (including this edge) with flag 0.
    always_comb begin
        rep_sel = '0;
        for (int c = int'(P_CH) - 1; c >= 0; c--) begin
            if (fin_nxt[c] && !fflag_nxt[c]) begin
                rep_sel.ch       = CH_IDX_W'(c);
                rep_sel.ftype    = type_a[c];
                rep_sel.index    = index_a[c];
                rep_sel.result   = result_a[c];
                rep_sel.expected = expect_a[c];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) state_q <= ST_RUN;
        else          state_q <= state_d;
    end

    // FSM next state; a deciding FINISH outranks watchdog expiry.
    always_comb begin
        state_d = state_q;
        if (iCLEAR) begin
            state_d = ST_RUN;
        end else if (state_q == ST_RUN) begin
            if (fin_acc && P_ABORT_ON_FAIL && !fflag_pad[ch_sel]) begin
                state_d = ST_FAIL;
            end else if (fin_acc && (&fin_nxt)) begin
                state_d = (&fflag_nxt) ? ST_PASS : ST_FAIL;
            end else if (wd_expire) begin
                state_d = ST_TIMEOUT;
            end
        end
    end

    // FSM outputs; the report is captured only on entry to FAIL.
    always_comb begin
        done_d   = (state_d != ST_RUN);
        pass_d   = (state_d == ST_PASS);
        fail_d   = (state_d == ST_FAIL);
        tout_d   = (state_d == ST_TIMEOUT);
        report_d = report_q;
        if (iCLEAR)                                     report_d = '0;
        else if ((state_q == ST_RUN) && (state_d == ST_FAIL)) report_d = rep_sel;
    end

    // Registered verdict, report, watchdog, counters.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            fail_q   <= 1'b0;
            tout_q   <= 1'b0;
            report_q <= '0;
            wd_q     <= '0;
            cnt_q    <= '0;
            bad_q    <= 1'b0;
        end else begin
            done_q   <= done_d;
            pass_q   <= pass_d;
            fail_q   <= fail_d;
            tout_q   <= tout_d;
            report_q <= report_d;
            if (iCLEAR) begin
                wd_q  <= '0;
                cnt_q <= '0;
                bad_q <= 1'b0;
            end else begin
                if (run && (wd_q != '1))  wd_q  <= wd_q + 32'd1;
                if (acc && (cnt_q != '1)) cnt_q <= cnt_q + 16'd1;
                if (bad)                  bad_q <= 1'b1;
            end
        end
    end

    assign oDONE          = done_q;
    assign oPASS          = pass_q;
    assign oFAIL          = fail_q;
    assign oTIMEOUT       = tout_q;
    assign oFINISHED_MASK = fin_q;
    assign oFAIL_CH       = report_q.ch;
    assign oFAIL_TYPE     = report_q.ftype;
    assign oFAIL_INDEX    = report_q.index;
    assign oFAIL_RESULT   = report_q.result;
    assign oFAIL_EXPECT   = report_q.expected;
    assign oBAD_ACCESS    = bad_q;
    assign oACCEPT_COUNT  = cnt_q;

endmodule
